// File: rtl/vga_timing_ctrl_if.sv
// VGA raster bundle: scan request in, pixel strobe / syncs / DE / coordinates out.
interface vga_timing_ctrl_if;
  logic       enable;
  logic       pixel_tick;
  logic       h_sync;
  logic       v_sync;
  logic       DE;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       line_start;
  logic       frame_start;

  modport master (
    output enable,
    input  pixel_tick, h_sync, v_sync, DE, x_pixel, y_pixel, line_start, frame_start
  );

  modport slave (
    input  enable,
    output pixel_tick, h_sync, v_sync, DE, x_pixel, y_pixel, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with a run/drain/idle FSM that only stops on a frame boundary.
// Decode is computed from next-state values and registered, so outputs change with the counters.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_ctrl_if.slave   bus_if
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;

  logic tick_q, tick_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  logic tick_c, h_last_c, v_last_c, frame_end_c, scan_d_c;

  // Next-state: counter advance, FSM transitions, and output decode of the next state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;

    tick_c      = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    h_last_c    = (h_q == 10'(H_TOTAL - 1));
    v_last_c    = (v_q == 10'(V_TOTAL - 1));
    frame_end_c = tick_c && h_last_c && v_last_c;

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (tick_c) begin
          div_d = '0;
          h_d   = h_last_c ? 10'd0 : h_q + 10'd1;
          if (h_last_c) begin
            v_d = v_last_c ? 10'd0 : v_q + 10'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        // A reasserted enable cancels the drain; otherwise stop once the frame completes
        if ((state_q == ST_DRAIN) && !bus_if.enable && frame_end_c) begin
          state_d = ST_IDLE;
          div_d   = '0;
          h_d     = 10'd0;
          v_d     = 10'd0;
        end else begin
          state_d = bus_if.enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        div_d = '0;
        h_d   = 10'd0;
        v_d   = 10'd0;
        state_d = bus_if.enable ? ST_RUN : ST_IDLE;
      end
    endcase

    scan_d_c = (state_d != ST_IDLE);
    tick_d   = scan_d_c && (div_d == DIV_LAST);
    de_d     = scan_d_c && (h_d < 10'(H_VISIBLE)) && (v_d < 10'(V_VISIBLE));
    hs_d     = (scan_d_c && (h_d >= 10'(HS_START)) && (h_d < 10'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    vs_d     = (scan_d_c && (v_d >= 10'(VS_START)) && (v_d < 10'(VS_END))) ? SYNC_POL : ~SYNC_POL;
    ls_d     = tick_d && (h_d == 10'd0);
    fs_d     = ls_d && (v_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      tick_q  <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      tick_q  <= tick_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign bus_if.pixel_tick  = tick_q;
  assign bus_if.h_sync      = hs_q;
  assign bus_if.v_sync      = vs_q;
  assign bus_if.DE          = de_q;
  assign bus_if.x_pixel     = h_q;
  assign bus_if.y_pixel     = v_q;
  assign bus_if.line_start  = ls_q;
  assign bus_if.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: small-raster builds (CLK_DIV=2 and CLK_DIV=1) checked against
// constant vectors, measured pulse/frame lengths, and a frame-clock reference model.
module tb_vga_timing_ctrl;

  localparam int HV = 8, HFP = 2, HSY = 3, HBP = 2;
  localparam int VV = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HV + HFP + HSY + HBP;   // 15
  localparam int VT = VV + VFP + VSY + VBP;   // 11
  localparam int DIV_A = 2;
  localparam int DIV_B = 1;
  localparam int FRAME_A = HT * VT * DIV_A;   // 330
  localparam int FRAME_B = HT * VT * DIV_B;   // 165
  localparam bit SP = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if ifa ();
  vga_timing_ctrl_if ifb ();
  assign ifa.enable = en;
  assign ifb.enable = en;

  vga_timing_ctrl #(.CLK_DIV(DIV_A), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(SP))
    dut_a (.clk(clk), .reset(rst), .bus_if(ifa.slave));

  vga_timing_ctrl #(.CLK_DIV(DIV_B), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(SP))
    dut_b (.clk(clk), .reset(rst), .bus_if(ifb.slave));

  // Reference model: scanning is a single clock count t into the frame; st 0=stopped 1=run 2=drain
  typedef struct { int st; int t; } mdl_t;
  mdl_t ma = '{0, 0};
  mdl_t mb = '{0, 0};

  function automatic mdl_t step(mdl_t m, logic r, logic e, int frame);
    mdl_t n;
    n = m;
    if (r) begin
      n.st = 0; n.t = 0;
    end else if (m.st == 0) begin
      n.st = e ? 1 : 0; n.t = 0;
    end else if (m.st == 2 && !e && m.t == frame - 1) begin
      n.st = 0; n.t = 0;
    end else begin
      n.t  = (m.t + 1) % frame;
      n.st = e ? 1 : 2;
    end
    return n;
  endfunction

  function automatic logic [25:0] mdl_out(mdl_t m, int div);
    int p, x, y;
    logic tk, hs, vs, de;
    if (m.st == 0) return {1'b0, ~SP, ~SP, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    p  = m.t / div;
    x  = p % HT;
    y  = p / HT;
    tk = ((m.t % div) == div - 1);
    de = (x < HV) && (y < VV);
    hs = (x >= HV + HFP && x < HV + HFP + HSY) ? SP : ~SP;
    vs = (y >= VV + VFP && y < VV + VFP + VSY) ? SP : ~SP;
    return {tk, hs, vs, de, tk && x == 0, tk && x == 0 && y == 0, 10'(x), 10'(y)};
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, rst, en, FRAME_A);
    mb <= step(mb, rst, en, FRAME_B);
  end

  function automatic logic [25:0] outa();
    return {ifa.pixel_tick, ifa.h_sync, ifa.v_sync, ifa.DE, ifa.line_start, ifa.frame_start,
            ifa.x_pixel, ifa.y_pixel};
  endfunction

  function automatic logic [25:0] outb();
    return {ifb.pixel_tick, ifb.h_sync, ifb.v_sync, ifb.DE, ifb.line_start, ifb.frame_start,
            ifb.x_pixel, ifb.y_pixel};
  endfunction

  task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (tick,hs,vs,de,ls,fs,x,y) at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Advance one clock, sample on the falling edge, compare both builds with the model
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("model_a", outa(), mdl_out(ma, DIV_A));
    chk("model_b", outb(), mdl_out(mb, DIV_B));
  endtask

  typedef struct {
    logic r, e;
    int   n;
    logic tk, hs, vs, de, ls, fs;
    int   x, y;
  } vec_t;

  vec_t tbl[13];

  task automatic measure(input bit use_b, input string nm, input int exp_len,
                         input int exp_ticks, input int exp_hlow, input int exp_vlow);
    int cnt, tks, hl, vl, guard;
    bit fs;
    guard = 0;
    fs = use_b ? ifb.frame_start : ifa.frame_start;
    while (!fs && guard < 1000) begin
      cyc(); guard++;
      fs = use_b ? ifb.frame_start : ifa.frame_start;
    end
    chk_int({nm, "_wait_fs"}, int'(fs), 1);
    cnt = 0; tks = 0; hl = 0; vl = 0;
    do begin
      cnt++;
      tks += int'(use_b ? ifb.pixel_tick : ifa.pixel_tick);
      hl  += int'((use_b ? ifb.h_sync : ifa.h_sync) == SP);
      vl  += int'((use_b ? ifb.v_sync : ifa.v_sync) == SP);
      cyc();
      fs = use_b ? ifb.frame_start : ifa.frame_start;
    end while (!fs && cnt < 1000);
    chk_int({nm, "_frame_len"}, cnt, exp_len);
    chk_int({nm, "_ticks"}, tks, exp_ticks);
    chk_int({nm, "_hsync_clks"}, hl, exp_hlow);
    chk_int({nm, "_vsync_clks"}, vl, exp_vlow);
  endtask

  initial begin
    int  guard;
    bit  found;
    // {rst, en, clocks, tick, hs, vs, de, ls, fs, x, y} for the CLK_DIV=2 build
    tbl[0]  = '{1, 1,   3, 0, 1, 1, 0, 0, 0,  0,  0};
    tbl[1]  = '{0, 1,   1, 0, 1, 1, 1, 0, 0,  0,  0};
    tbl[2]  = '{0, 1,   1, 1, 1, 1, 1, 1, 1,  0,  0};
    tbl[3]  = '{0, 1,   1, 0, 1, 1, 1, 0, 0,  1,  0};
    tbl[4]  = '{0, 1,  18, 0, 0, 1, 0, 0, 0, 10,  0};
    tbl[5]  = '{0, 1,   6, 0, 1, 1, 0, 0, 0, 13,  0};
    tbl[6]  = '{0, 1,   4, 0, 1, 1, 1, 0, 0,  0,  1};
    tbl[7]  = '{0, 1, 180, 0, 1, 0, 0, 0, 0,  0,  7};
    tbl[8]  = '{0, 0,   1, 1, 1, 0, 0, 1, 0,  0,  7};
    tbl[9]  = '{0, 0, 118, 1, 1, 1, 0, 0, 0, 14, 10};
    tbl[10] = '{0, 0,   1, 0, 1, 1, 0, 0, 0,  0,  0};
    tbl[11] = '{0, 0,   5, 0, 1, 1, 0, 0, 0,  0,  0};
    tbl[12] = '{0, 1,   1, 0, 1, 1, 1, 0, 0,  0,  0};

    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r;
      en  = tbl[i].e;
      for (int k = 0; k < tbl[i].n; k++) cyc();
      chk($sformatf("vec%0d", i), outa(),
          {tbl[i].tk, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls, tbl[i].fs,
           10'(tbl[i].x), 10'(tbl[i].y)});
    end

    // Reset mid-frame aborts at once and the scan restarts at the origin
    found = 1'b0; guard = 0;
    while (!found && guard < 400) begin
      cyc(); guard++;
      found = (ifa.x_pixel == 10'd5) && (ifa.y_pixel == 10'd3);
    end
    chk_int("reach_x5_y3", int'(found), 1);
    rst = 1'b1;
    cyc();
    chk("reset_mid_frame", outa(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
    rst = 1'b0;
    cyc();
    chk("restart_after_reset", outa(), {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});

    // Whole-frame measurements: frame length, tick count, sync low widths
    measure(1'b0, "div2", FRAME_A, HT * VT, HSY * VT * DIV_A, VSY * HT * DIV_A);
    measure(1'b1, "div1", FRAME_B, FRAME_B, HSY * VT, VSY * HT);

    // Drain that is cancelled within the frame, then a completed drain
    en = 1'b0;
    for (int k = 0; k < 40; k++) cyc();
    en = 1'b1;
    for (int k = 0; k < 40; k++) cyc();
    en = 1'b0;
    for (int k = 0; k < FRAME_A + 10; k++) cyc();
    chk("drained_idle", outa(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});

    // Random enable/reset activity against the model
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      rst = ($urandom_range(0, 1999) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
